instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   Sequences fetches from the instruction memory. Holds the PC, issues word
//   requests, tags responses with their PC, buffers them in a prefetch FIFO and
//   hands (pc, instr) pairs to the decode stage via valid/ready. Handles
//   redirects (branch/jump) by flushing and discarding in-flight responses.
//   Sits between the pipeline IF stage and the instruction memory port.
// PARAMETERS
//   RESET_PC   32'h0  PC loaded at reset; fetch starts here on start_i
//   DEPTH      4      prefetch FIFO entries; power of 2, >=2; also caps in-flight
//   MEM_WORDS  65     instruction memory size in words; word index >= this halts
// PORTS
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   asynchronous, active-low reset
//   start_i        in   1   pulse: leave IDLE and begin fetching at current pc
//   redirect_i     in   1   pulse: flush and restart at redirect_pc_i
//   redirect_pc_i  in   32  new PC; bits [1:0] are forced to 0
//   imem_req_o     out  1   fetch request valid
//   imem_addr_o    out  32  byte address of request (word aligned)
//   imem_ready_i   in   1   memory accepts request this cycle
//   imem_rvalid_i  in   1   response valid; responses return in order
//   imem_rdata_i   in   32  response instruction word
//   instr_valid_o  out  1   FIFO head valid
//   instr_ready_i  in   1   decode consumes head
//   instr_o        out  32  head instruction
//   pc_o           out  32  head PC
//   halted_o       out  1   HALT, FIFO empty, nothing in flight
// BEHAVIOUR
//   Reset: state IDLE, pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop=0,
//     FIFO empty; all outputs 0 (imem_addr_o = pc = RESET_PC, driven comb).
//   States: IDLE -start_i-> FETCH; FETCH -(pc[31:2]>=MEM_WORDS)-> HALT;
//     FETCH/HALT -redirect_i-> FETCH (pc=redirect_pc_i). start_i outside IDLE
//     ignored. redirect_i in IDLE loads pc, stays IDLE.
//   imem_req_o = FETCH & !redirect_i & pc[31:2]<MEM_WORDS &
//     (outstanding + fifo_count) < DEPTH. Credit rule guarantees no overflow.
//   req&ready: pc+=4, outstanding+=1. Memory latency L -> instr_valid_o
//     earliest at accept cycle + L + 1 (FIFO is show-ahead, head registered).
//   rvalid: outstanding-=1; if drop>0 then drop-=1 (discard) else push
//     {rsp_pc, rdata}, rsp_pc+=4. rvalid with outstanding==0 ignored, no underflow.
//   Pop on instr_valid_o & instr_ready_i. Push and pop same cycle allowed,
//     including at full/empty boundaries (empty: push-then-visible next cycle).
//   Redirect (priority over all): FIFO cleared, pop suppressed, rvalid that
//     cycle discarded, drop <= outstanding - rvalid, outstanding <= same minus
//     nothing else (no request issued), pc=rsp_pc=redirect_pc_i&~3.
//   halted_o = HALT & fifo empty & outstanding==0.
//   pc arithmetic 32-bit wrap-around; counters sized $clog2(DEPTH)+1.
//   Reset asserted mid-operation: immediate return to reset values; responses
//     arriving after reset release with outstanding==0 ignored.
// STRUCTURE
//   Package ifu_pkg: state enum {IFU_IDLE, IFU_FETCH, IFU_HALT}, PC_STEP=4,
//     entry width constant (64: pc+instr).
//   Sub-module ifu_fifo: sync show-ahead FIFO (DEPTH x 64), push/pop/flush,
//     count/empty/full. Controller FSM, pc/rsp_pc, credit/drop counters in top.
// TESTING
//   1 Reset, start_i, L=1, ready=1, decode ready=1 -> pairs (0,I0),(4,I1),...
//     in order, one per cycle after 2-cycle fill.
//   2 instr_ready_i=0 -> exactly DEPTH=4 requests then imem_req_o=0; ready=1
//     -> requests resume the cycle after first pop.
//   3 4 in flight, redirect_i pc=0x40 -> next 4 rvalid dropped, first
//     output pc_o=0x40 with mem[16]; FIFO empty cycle after redirect.
//   4 Run to pc=0x104 (index 65) -> no further req, FIFO drains, halted_o=1;
//     redirect pc=0x8 -> FETCH, halted_o=0, output pc 0x8.
//   5 imem_ready_i toggled randomly, L=3 -> no loss/duplication, addr stable
//     while req&!ready.
//   6 rst_i low mid-stream with 2 in flight -> outputs 0 immediately; late
//     rvalid after release ignored; restart at RESET_PC on start_i.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch controller
package ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_FETCH,
        IFU_HALT
    } ifu_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // One prefetch entry is {pc, instr}
    localparam int ENTRY_W = 64;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - instruction memory and decode handshake bundle
interface instr_fetch_ctrl_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o
    );

endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - show-ahead prefetch FIFO with flush
import ifu_pkg::*;

module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CW-1:0]      count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy update; flush wins over everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencing, credit-limited fetch and redirect handling
import ifu_pkg::*;

module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          DEPTH     = 4,
    parameter int          MEM_WORDS = 65
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    instr_fetch_ctrl_if.master        bus,
    output logic                      halted_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    ifu_state_e         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      drop_q, drop_d;

    logic [ENTRY_W-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty, fifo_full;
    logic               in_range, credit_ok, req, accept, rsp_ok, push, pop;
    logic [31:0]        redirect_pc_al;

    assign redirect_pc_al = redirect_pc_i & ~32'h3;
    assign in_range  = (pc_q[31:2] < 30'(MEM_WORDS));
    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow
    assign credit_ok = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W);
    assign req       = (state_q == IFU_FETCH) && !redirect_i && in_range && credit_ok;
    assign accept    = req && bus.imem_ready_i;
    // Stray responses with nothing outstanding (e.g. after reset) are ignored
    assign rsp_ok    = bus.imem_rvalid_i && (outstanding_q != '0);
    assign pop       = !fifo_empty && bus.instr_ready_i && !redirect_i;
    assign push      = rsp_ok && (drop_q == '0) && !redirect_i && (!fifo_full || pop);

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = !fifo_empty;
    assign bus.instr_o       = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign bus.pc_o          = fifo_empty ? 32'h0 : fifo_head[63:32];
    assign halted_o          = (state_q == IFU_HALT) && fifo_empty && (outstanding_q == '0);

    ifu_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i ({rsp_pc_q, bus.imem_rdata_i}),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Next state, PC and credit/drop bookkeeping; redirect overrides normal progress
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_i) begin
            pc_d          = redirect_pc_al;
            rsp_pc_d      = redirect_pc_al;
            // Everything still in flight belongs to the old path and must be discarded
            outstanding_d = outstanding_q - CW'(rsp_ok);
            drop_d        = outstanding_q - CW'(rsp_ok);
            if (state_q != IFU_IDLE) state_d = IFU_FETCH;
        end else begin
            case (state_q)
                IFU_IDLE:  if (start_i)   state_d = IFU_FETCH;
                IFU_FETCH: if (!in_range) state_d = IFU_HALT;
                IFU_HALT:  state_d = IFU_HALT;
                default:   state_d = IFU_IDLE;
            endcase
            if (accept) pc_d = pc_q + PC_STEP;
            outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);
            if (rsp_ok) begin
                if (drop_q != '0) drop_d   = drop_q - CW'(1);
                else              rsp_pc_d = rsp_pc_q + PC_STEP;
            end
        end
    end

    // Controller state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IFU_IDLE;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halted;

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(
        .RESET_PC  (32'h0),
        .DEPTH     (4),
        .MEM_WORDS (65)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .bus           (bus),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    int          n_pop = 0;
    int          g;
    int          n0;
    logic [31:0] exp_pc = 32'h0;
    logic        s_req = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;
    req_t        pq[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: memory model drives the response, outputs are sampled, then the clock edge
    task automatic tick();
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = memword(pq[0].addr);
            void'(pq.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
        end
        #1;
        s_req = bus.imem_req_o;
        if (rst_i && !redirect_i && stall_prev) begin
            chk("stall_req_hold", {31'h0, bus.imem_req_o}, 32'h1);
            chk("stall_addr_hold", bus.imem_addr_o, addr_prev);
        end
        stall_prev = rst_i && bus.imem_req_o && !bus.imem_ready_i;
        addr_prev  = bus.imem_addr_o;
        if (bus.imem_req_o && bus.imem_ready_i) begin
            pq.push_back('{bus.imem_addr_o, cyc + lat});
            n_acc++;
        end
        if (rst_i && !redirect_i && bus.instr_valid_o && bus.instr_ready_i) begin
            chk("pop_pc", bus.pc_o, exp_pc);
            chk("pop_instr", bus.instr_o, memword(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        start_i    = 1'b0;
        redirect_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        bus.imem_ready_i = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = 32'h0;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("rst_req", {31'h0, bus.imem_req_o}, 32'h0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        tick();
        chk("idle_no_req", {31'h0, s_req}, 32'h0);

        // 1: streaming at L=1, first pair after a 2-cycle fill
        lat = 1;
        n_pop = 0;
        start_i = 1'b1;
        repeat (10) tick();
        chk("t1_pop_count", n_pop, 32'd7);

        // 2: decode stalled -> exactly 4 requests, resume one cycle after first pop
        bus.instr_ready_i = 1'b0;
        redirect_pc_i = 32'h20;
        redirect_i = 1'b1;
        exp_pc = 32'h20;
        tick();
        n_acc = 0;
        repeat (10) tick();
        chk("t2_req_count", n_acc, 32'd4);
        chk("t2_req_off", {31'h0, bus.imem_req_o}, 32'h0);
        chk("t2_head_pc", bus.pc_o, 32'h20);
        bus.instr_ready_i = 1'b1;
        tick();
        chk("t2_req_at_pop", {31'h0, s_req}, 32'h0);
        tick();
        chk("t2_req_resume", {31'h0, s_req}, 32'h1);
        repeat (6) tick();

        // 3: four in flight at L=6, redirect drops them all
        lat = 6;
        g = 0;
        while (pq.size() < 4 && g < 40) begin
            tick();
            g++;
        end
        chk("t3_inflight", pq.size(), 32'd4);
        redirect_pc_i = 32'h40;
        redirect_i = 1'b1;
        exp_pc = 32'h40;
        tick();
        chk("t3_empty_after", {31'h0, bus.instr_valid_o}, 32'h0);
        n0 = n_pop;
        g = 0;
        while (n_pop == n0 && g < 40) begin
            tick();
            g++;
        end
        chk("t3_restarted", {31'h0, n_pop != n0}, 32'h1);
        repeat (8) tick();

        // 4: run off the end of memory, halt, then redirect out of HALT
        lat = 1;
        redirect_pc_i = 32'hF0;
        redirect_i = 1'b1;
        exp_pc = 32'hF0;
        tick();
        g = 0;
        while (!halted && g < 80) begin
            tick();
            g++;
        end
        chk("t4_halted", {31'h0, halted}, 32'h1);
        chk("t4_last_pc", exp_pc, 32'h104);
        n_acc = 0;
        repeat (3) tick();
        chk("t4_no_req", n_acc, 32'd0);
        chk("t4_addr", bus.imem_addr_o, 32'h104);
        redirect_pc_i = 32'h0000000B;
        redirect_i = 1'b1;
        exp_pc = 32'h8;
        tick();
        chk("t4_unhalted", {31'h0, halted}, 32'h0);
        n0 = n_pop;
        g = 0;
        while (n_pop == n0 && g < 20) begin
            tick();
            g++;
        end
        chk("t4_restarted", {31'h0, n_pop != n0}, 32'h1);

        // 5: random memory back-pressure at L=3
        lat = 3;
        n0 = n_pop;
        for (int i = 0; i < 60; i++) begin
            bus.imem_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.imem_ready_i = 1'b1;
        repeat (8) tick();
        chk("t5_progress", {31'h0, (n_pop - n0) >= 10}, 32'h1);

        // 6: reset mid-stream, late responses ignored, clean restart
        lat = 4;
        g = 0;
        while (pq.size() < 2 && g < 20) begin
            tick();
            g++;
        end
        chk("t6_inflight", {31'h0, pq.size() >= 2}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("t6_req", {31'h0, bus.imem_req_o}, 32'h0);
        chk("t6_addr", bus.imem_addr_o, 32'h0);
        chk("t6_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("t6_instr", bus.instr_o, 32'h0);
        chk("t6_pc", bus.pc_o, 32'h0);
        tick();
        rst_i = 1'b1;
        exp_pc = 32'h0;
        n_acc = 0;
        n0 = n_pop;
        repeat (8) tick();
        chk("t6_no_req", n_acc, 32'd0);
        chk("t6_no_pop", n_pop - n0, 32'd0);
        chk("t6_pq_drained", pq.size(), 32'd0);
        lat = 1;
        start_i = 1'b1;
        repeat (10) tick();
        chk("t6_restart_pops", n_pop - n0, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
